loop_sequencer: RTL
===================

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 Parameter CNT_W, default 4, width of the outer/inner loop counts (the instruction register-field width).
REQ-002 Parameter AW, default 32, PC/address width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start_i  input  1  loop-call instruction decoded this cycle (single-cycle pulse from control).
REQ-006 outer_i  input  CNT_W  outer repeat count, sampled on accepted start.
REQ-007 inner_i  input  CNT_W  body length in instructions, sampled on accepted start.
REQ-008 target_i  input  AW  body start address, sampled on accepted start.
REQ-009 ret_i  input  AW  return address (call PC + 4), sampled on accepted start.
REQ-010 pc_seq_i  input  AW  sequential/branch next PC from the datapath mux.
REQ-011 pc_next_o  output  AW  next PC selected for the PC register (combinational).
REQ-012 busy_o  output  1  sequencer in RUN.
REQ-013 done_o  output  1  one-cycle pulse, cycle after return is issued.
REQ-014 iter_o  output  CNT_W  outer iterations remaining after the current pass.

Function
REQ-015 States IDLE, RUN; busy_o = (state == RUN).
REQ-016 IDLE, start_i=0: pc_next_o = pc_seq_i; no state change.
REQ-017 IDLE, start_i=1, outer_i and inner_i both nonzero: pc_next_o = target_i; latch target, ret, inner; inner_left <= inner_i-1; outer_left <= outer_i-1; go RUN.
REQ-018 IDLE, start_i=1, outer_i==0 or inner_i==0: pc_next_o = ret_i; stay IDLE; done_o pulses next cycle.
REQ-019 RUN, inner_left>0: pc_next_o = pc_seq_i; inner_left decrements.
REQ-020 RUN, inner_left==0, outer_left>0: pc_next_o = latched target; inner_left <= latched inner-1; outer_left decrements.
REQ-021 RUN, inner_left==0, outer_left==0: pc_next_o = latched ret; go IDLE; done_o high the following cycle only.
REQ-022 Body executes exactly outer*inner instructions between the call and the return.
REQ-023 start_i during RUN is ignored (no nesting); counters and pc_next_o unaffected.
REQ-024 Counters unsigned, never wrap below zero; all count arithmetic at CNT_W bits.
REQ-025 iter_o = outer_left in RUN, 0 in IDLE.

Reset
REQ-026 rst asserted: state=IDLE, all counters and latched target/ret cleared, busy_o=0, done_o=0, iter_o=0, immediately and asynchronously.
REQ-027 rst mid-loop abandons the loop; first cycle after release behaves per REQ-016/017.

Configuration
REQ-028 LOOP_SEQ_ABORT_EN defined: adds input abort_i (1 bit); abort_i=1 in RUN forces pc_next_o = latched ret, state to IDLE, done_o pulse next cycle; abort_i has priority over REQ-019..021; ignored in IDLE.
REQ-029 LOOP_SEQ_ABORT_EN undefined: no abort_i port; behaviour exactly REQ-015..025.

Structure
REQ-030 Package loop_seq_pkg holds the state enum, CNT_W/AW defaults and the REQ-013 pulse constant width.
REQ-031 One sub-module loop_down_counter (load, decrement, zero flag), instantiated twice for inner and outer counts.

Verification
REQ-032 outer=2, inner=3, target=0x10, ret=0x08, pc_seq=PC+4 -> pc_next sequence 0x10,0x14,0x18,0x10,0x14,0x18,0x08; busy high 6 cycles; done one cycle after 0x08.
REQ-033 outer=1, inner=1, target=0x20, ret=0x0C -> pc_next 0x20 then 0x0C; busy 1 cycle.
REQ-034 outer=0, inner=5, ret=0x04 -> pc_next=0x04 on start cycle, busy never high, done next cycle.
REQ-035 start_i pulsed again at RUN cycle 2 of REQ-032 run -> identical output sequence.
REQ-036 rst asserted at RUN cycle 3 of REQ-032 -> busy_o, iter_o, done_o 0 immediately; pc_next_o = pc_seq_i after release.
REQ-037 LOOP_SEQ_ABORT_EN: abort_i at RUN cycle 2 of REQ-032 -> pc_next_o=0x08 that cycle, IDLE next, done pulse.

Source files
------------

// File: rtl/loop_seq_pkg.sv
// Shared types and defaults for the loop sequencer.
package loop_seq_pkg;

  localparam int unsigned CNT_W_DEF    = 4;   // outer/inner count field width
  localparam int unsigned AW_DEF       = 32;  // PC/address width
  localparam int unsigned DONE_PULSE_W = 1;   // width of the done pulse register

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/loop_down_counter.sv
// Loadable down counter with a zero flag; it saturates at zero instead of
// wrapping.
module loop_down_counter
  import loop_seq_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  // Next count: a load wins over a decrement, and a decrement at zero is a no-op.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  // NOTE: clocked state uses non-blocking (<=) assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/loop_sequencer.sv
// Hardware loop sequencer: on a loop-call it redirects the PC to the body,
// replays the body outer*inner instructions, then returns to the caller.
// Optional feature: define LOOP_SEQ_ABORT_EN to add the abort_i input, which
// forces an early return from RUN.
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef LOOP_SEQ_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             start_i,
  input  logic [CNT_W-1:0] outer_i,
  input  logic [CNT_W-1:0] inner_i,
  input  logic [AW-1:0]    target_i,
  input  logic [AW-1:0]    ret_i,
  input  logic [AW-1:0]    pc_seq_i,
  output logic [AW-1:0]    pc_next_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] iter_o
);

  seq_state_e              state_q, state_d;
  logic [AW-1:0]           target_q, target_d;
  logic [AW-1:0]           ret_q, ret_d;
  logic [CNT_W-1:0]        inner_len_q, inner_len_d;
  logic [DONE_PULSE_W-1:0] done_q, done_d;

  logic             in_load, in_dec, in_zero;
  logic [CNT_W-1:0] in_val, inner_left;
  logic             out_load, out_dec, out_zero;
  logic [CNT_W-1:0] out_val, outer_left;
  logic             abort_req;
  logic             unused_inner;

`ifdef LOOP_SEQ_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  // The inner count value itself is only needed through its zero flag.
  assign unused_inner = ^inner_left;

  loop_down_counter #(.W(CNT_W)) u_inner_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (in_load),
    .load_val_i (in_val),
    .dec_i      (in_dec),
    .count_o    (inner_left),
    .zero_o     (in_zero)
  );

  loop_down_counter #(.W(CNT_W)) u_outer_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (out_load),
    .load_val_i (out_val),
    .dec_i      (out_dec),
    .count_o    (outer_left),
    .zero_o     (out_zero)
  );

  // Next-state, PC selection and counter control.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d     = state_q;
    target_d    = target_q;
    ret_d       = ret_q;
    inner_len_d = inner_len_q;
    done_d      = '0;
    pc_next_o   = pc_seq_i;
    in_load     = 1'b0;
    in_val      = '0;
    in_dec      = 1'b0;
    out_load    = 1'b0;
    out_val     = '0;
    out_dec     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if ((outer_i != '0) && (inner_i != '0)) begin
            pc_next_o   = target_i;
            target_d    = target_i;
            ret_d       = ret_i;
            inner_len_d = inner_i;
            in_load     = 1'b1;
            in_val      = inner_i - CNT_W'(1);
            out_load    = 1'b1;
            out_val     = outer_i - CNT_W'(1);
            state_d     = ST_RUN;
          end else begin
            // Empty loop: return straight away without entering RUN.
            pc_next_o = ret_i;
            done_d    = '1;
          end
        end
      end

      ST_RUN: begin
        if (abort_req) begin
          // Early return; clear the counters so no stale count lingers.
          pc_next_o = ret_q;
          state_d   = ST_IDLE;
          done_d    = '1;
          in_load   = 1'b1;
          out_load  = 1'b1;
        end else if (!in_zero) begin
          in_dec = 1'b1;
        end else if (!out_zero) begin
          // End of a pass with passes remaining: restart the body.
          pc_next_o = target_q;
          in_load   = 1'b1;
          in_val    = inner_len_q - CNT_W'(1);
          out_dec   = 1'b1;
        end else begin
          pc_next_o = ret_q;
          state_d   = ST_IDLE;
          done_d    = '1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched call operands and done pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      ret_q       <= '0;
      inner_len_q <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      ret_q       <= ret_d;
      inner_len_q <= inner_len_d;
      done_q      <= done_d;
    end
  end

  assign busy_o = (state_q == ST_RUN);
  assign done_o = |done_q;
  assign iter_o = (state_q == ST_RUN) ? outer_left : '0;

endmodule
